e_mdu: RTL and testbench

- Multiply/divide unit in the E stage, beside the ALU.
- Consumes the forwarded E-stage rs/rt operands and owns the HI/LO registers.
- Its read result joins the E-to-M datapath as an additional GRF write-data source.
- Its Busy output feeds the global stall logic, so D-stage mult/div/mfhi/mflo/mthi/mtlo are held while an operation is in flight.

---
 rtl/e_mdu.sv | 231 +++++++++++++++++++++++
 tb/tb_e_mdu.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// ---------------------------------------------------------------------------
// e_mdu : E-stage multiply/divide unit
//
// Sits beside the ALU in the E stage. Consumes the forwarded rs/rt operands,
// owns the architectural HI/LO registers and supplies mfhi/mflo data to the
// E-to-M datapath. Busy feeds the global stall logic so that later MDU
// instructions are held in D while a mult/div is in flight.
//
// A mult/div result is computed in the Start cycle into pending registers.
// It is committed to HI/LO only after a fixed latency, which models the
// timing of an iterative unit.
//
// Ports:
//   clk    in   1   pipeline clock
//   reset  in   1   synchronous, active-high; clears all state
//   Start  in   1   an MDU instruction is valid in E this cycle
//   MDUOp  in   4   0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                   5 mthi, 6 mtlo, 7 mfhi, 8 mflo
//   A      in  32   forwarded rs operand
//   B      in  32   forwarded rt operand
//   Busy   out  1   high while a mult/div is in flight
//   HI     out 32   committed HI register
//   LO     out 32   committed LO register
//   Out    out 32   combinational read: HI for mfhi, LO for mflo, else 0
// ---------------------------------------------------------------------------
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] Out
);

  // Operation encodings
  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  // FSM states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Counter wide enough for the longer of the two latencies
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  // -------------------------------------------------------------------------
  // Arithmetic helper: returns {hi, lo} for the requested operation.
  // Signed divide works on magnitudes and re-applies the signs afterwards,
  // so 0x80000000 / -1 wraps to 0x80000000 with remainder 0 instead of
  // depending on tool behaviour for signed overflow. Divide-by-zero and
  // non-arithmetic ops return the current HI/LO, so a commit leaves them
  // unchanged.
  // -------------------------------------------------------------------------
  function automatic logic [63:0] mdu_calc(
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] hi,
    input logic [31:0] lo
  );
    logic [63:0] res;
    logic [63:0] a_sext;
    logic [63:0] b_sext;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_signed;
    logic [31:0] r_signed;
    res      = {hi, lo};
    a_sext   = {{32{a[31]}}, a};
    b_sext   = {{32{b[31]}}, b};
    mag_a    = a[31] ? (32'd0 - a) : a;
    mag_b    = b[31] ? (32'd0 - b) : b;
    q_mag    = 32'd0;
    r_mag    = 32'd0;
    q_signed = 32'd0;
    r_signed = 32'd0;
    case (op)
      OP_MULT: begin
        // Low 64 bits of the product of the sign-extended operands
        res = a_sext * b_sext;
      end
      OP_MULTU: begin
        res = {32'd0, a} * {32'd0, b};
      end
      OP_DIV: begin
        if (b != 32'd0) begin
          q_mag    = mag_a / mag_b;
          r_mag    = mag_a % mag_b;
          q_signed = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
          r_signed = a[31] ? (32'd0 - r_mag) : r_mag;
          res      = {r_signed, q_signed};
        end else begin
          res = {hi, lo};
        end
      end
      OP_DIVU: begin
        if (b != 32'd0) begin
          res = {a % b, a / b};
        end else begin
          res = {hi, lo};
        end
      end
      default: begin
        res = {hi, lo};
      end
    endcase
    return res;
  endfunction

  // State
  logic [0:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;
  logic [31:0]      pend_hi_r;
  logic [31:0]      pend_lo_r;

  // Combinational next values
  logic [63:0]      calc_s;
  logic [31:0]      out_s;

  // Candidate mult/div result from the operands currently in E
  always_comb begin
    calc_s = mdu_calc(MDUOp, A, B, hi_r, lo_r);
  end

  // Control FSM, latency counter, pending result and HI/LO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      busy_r    <= 1'b0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (Start) begin
            case (MDUOp)
              OP_MULT, OP_MULTU: begin
                pend_hi_r <= calc_s[63:32];
                pend_lo_r <= calc_s[31:0];
                cnt_r     <= MULT_LOAD;
                busy_r    <= 1'b1;
                state_r   <= ST_RUN;
              end
              OP_DIV, OP_DIVU: begin
                pend_hi_r <= calc_s[63:32];
                pend_lo_r <= calc_s[31:0];
                cnt_r     <= DIV_LOAD;
                busy_r    <= 1'b1;
                state_r   <= ST_RUN;
              end
              OP_MTHI: begin
                hi_r <= A;
              end
              OP_MTLO: begin
                lo_r <= A;
              end
              default: begin
                // none / mfhi / mflo: no state change
                state_r <= ST_IDLE;
              end
            endcase
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // Start is ignored here; the stall logic keeps MDU ops out of E
          if (cnt_r == CNT_ONE) begin
            hi_r    <= pend_hi_r;
            lo_r    <= pend_lo_r;
            busy_r  <= 1'b0;
            cnt_r   <= CNT_ZERO;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  // mfhi/mflo read port, no latency
  always_comb begin
    out_s = 32'd0;
    case (MDUOp)
      OP_MFHI: out_s = hi_r;
      OP_MFLO: out_s = lo_r;
      OP_NONE: out_s = 32'd0;
      default: out_s = 32'd0;
    endcase
  end

  assign Busy = busy_r;
  assign HI   = hi_r;
  assign LO   = lo_r;
  assign Out  = out_s;

endmodule

// File: tb/tb_e_mdu.sv
// ---------------------------------------------------------------------------
// tb_e_mdu : self-checking bench for e_mdu
//
// Directed scenarios followed by randomized operations, all compared against
// a reference model that computes results with 64-bit integer arithmetic
// and tracks the architectural HI/LO values.
// ---------------------------------------------------------------------------
module tb_e_mdu;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] Out;

  int n_tests;
  int n_fail;

  // Reference architectural state
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  e_mdu #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .Start(Start),
    .MDUOp(MDUOp),
    .A    (A),
    .B    (B),
    .Busy (Busy),
    .HI   (HI),
    .LO   (LO),
    .Out  (Out)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result {hi, lo} using plain 64-bit integer arithmetic
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
    longint          sa;
    longint          sb;
    longint          q;
    longint          r;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned uq;
    longint unsigned ur;
    logic [63:0]     res;
    sa  = longint'(signed'(a));
    sb  = longint'(signed'(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    res = {hi, lo};
    case (op)
      4'd1: begin q = sa * sb; res = q; end
      4'd2: begin uq = ua * ub; res = uq; end
      4'd3: if (b != 32'd0) begin
              q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]};
            end else begin
              res = {hi, lo};
            end
      4'd4: if (b != 32'd0) begin
              uq = ua / ub; ur = ua % ub; res = {ur[31:0], uq[31:0]};
            end else begin
              res = {hi, lo};
            end
      default: res = {hi, lo};
    endcase
    return res;
  endfunction

  // mult/div: Busy must be high for exactly the latency, HI/LO held meanwhile.
  // stray_at >= 0 injects an mtlo Start during that busy cycle.
  task automatic do_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int stray_at);
    logic [63:0] r;
    int          n;
    r = ref_result(op, a, b, m_hi, m_lo);
    n = (op == 4'd1 || op == 4'd2) ? 5 : 10;
    Start = 1'b1; MDUOp = op; A = a; B = b;
    @(posedge clk); #1;
    Start = 1'b0; MDUOp = 4'd0; A = $urandom; B = $urandom;
    for (int i = 0; i < n; i++) begin
      check_eq("busy_run", {31'd0, Busy}, 32'd1);
      check_eq("hi_hold", HI, m_hi);
      check_eq("lo_hold", LO, m_lo);
      if (i == stray_at) begin
        Start = 1'b1; MDUOp = 4'd6; A = 32'h0000AAAA;
      end
      @(posedge clk); #1;
      Start = 1'b0; MDUOp = 4'd0;
    end
    m_hi = r[63:32];
    m_lo = r[31:0];
    check_eq("busy_done", {31'd0, Busy}, 32'd0);
    check_eq("hi_commit", HI, m_hi);
    check_eq("lo_commit", LO, m_lo);
  endtask

  // mthi/mtlo: single-cycle write, Busy stays low
  task automatic do_mt(input logic [3:0] op, input logic [31:0] a);
    Start = 1'b1; MDUOp = op; A = a;
    @(posedge clk); #1;
    Start = 1'b0; MDUOp = 4'd0;
    if (op == 4'd5) m_hi = a;
    else m_lo = a;
    check_eq("mt_busy", {31'd0, Busy}, 32'd0);
    check_eq("mt_hi", HI, m_hi);
    check_eq("mt_lo", LO, m_lo);
  endtask

  // Start with an op that must not change any state
  task automatic do_nop(input logic [3:0] op, input logic [31:0] a);
    Start = 1'b1; MDUOp = op; A = a; B = ~a;
    @(posedge clk); #1;
    Start = 1'b0; MDUOp = 4'd0;
    check_eq("nop_busy", {31'd0, Busy}, 32'd0);
    check_eq("nop_hi", HI, m_hi);
    check_eq("nop_lo", LO, m_lo);
  endtask

  // Combinational read port
  task automatic check_out();
    MDUOp = 4'd7; #1;
    check_eq("out_mfhi", Out, m_hi);
    MDUOp = 4'd8; #1;
    check_eq("out_mflo", Out, m_lo);
    MDUOp = 4'd0; #1;
    check_eq("out_none", Out, 32'd0);
    @(posedge clk); #1;
  endtask

  // Main stimulus
  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    n_tests = 0;
    n_fail  = 0;
    m_hi    = 32'd0;
    m_lo    = 32'd0;
    reset   = 1'b1;
    Start   = 1'b0;
    MDUOp   = 4'd0;
    A       = 32'd0;
    B       = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("rst_busy", {31'd0, Busy}, 32'd0);
    check_eq("rst_hi", HI, 32'd0);
    check_eq("rst_lo", LO, 32'd0);
    check_eq("rst_out", Out, 32'd0);

    // Signed multiply
    do_md(4'd1, 32'hFFFFFFFE, 32'd3, -1);
    check_eq("tp_mult_hi", HI, 32'hFFFFFFFF);
    check_eq("tp_mult_lo", LO, 32'hFFFFFFFA);
    check_out();

    // Unsigned multiply
    do_md(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
    check_eq("tp_multu_hi", HI, 32'hFFFFFFFE);
    check_eq("tp_multu_lo", LO, 32'h00000001);

    // Signed and unsigned divide
    do_md(4'd3, 32'hFFFFFFF9, 32'd2, -1);
    check_eq("tp_div_lo", LO, 32'hFFFFFFFD);
    check_eq("tp_div_hi", HI, 32'hFFFFFFFF);
    do_md(4'd4, 32'd7, 32'd2, -1);
    check_eq("tp_divu_lo", LO, 32'd3);
    check_eq("tp_divu_hi", HI, 32'd1);

    // Divide-by-zero preserves HI/LO; signed overflow case
    do_mt(4'd5, 32'h00001234);
    do_mt(4'd6, 32'h00005678);
    do_md(4'd3, 32'd5, 32'd0, -1);
    check_eq("tp_dz_hi", HI, 32'h00001234);
    check_eq("tp_dz_lo", LO, 32'h00005678);
    do_md(4'd4, 32'd5, 32'd0, -1);
    check_eq("tp_dzu_lo", LO, 32'h00005678);
    do_md(4'd3, 32'h80000000, 32'hFFFFFFFF, -1);
    check_eq("tp_ovf_lo", LO, 32'h80000000);
    check_eq("tp_ovf_hi", HI, 32'd0);

    // Start while busy is ignored
    do_md(4'd1, 32'd2, 32'd3, 1);
    check_eq("tp_stray_lo", LO, 32'd6);
    check_eq("tp_stray_hi", HI, 32'd0);

    // Non-state ops
    do_nop(4'd0, 32'hDEADBEEF);
    do_nop(4'd7, 32'hDEADBEEF);
    do_nop(4'd8, 32'hDEADBEEF);

    // Reset in the middle of a divide
    do_mt(4'd5, 32'h0BADF00D);
    Start = 1'b1; MDUOp = 4'd3; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    Start = 1'b0; MDUOp = 4'd0;
    repeat (3) begin
      check_eq("rmid_busy", {31'd0, Busy}, 32'd1);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    check_eq("rmid_busy_clr", {31'd0, Busy}, 32'd0);
    check_eq("rmid_hi", HI, 32'd0);
    check_eq("rmid_lo", LO, 32'd0);
    do_md(4'd1, 32'd4, 32'd5, -1);
    check_eq("rmid_mult_lo", LO, 32'd20);

    // Randomized operations
    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(0, 8));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: a = {{28{a[31]}}, a[3:0]};
        default: b = b;
      endcase
      case (op)
        4'd1, 4'd2, 4'd3, 4'd4: do_md(op, a, b, -1);
        4'd5, 4'd6:             do_mt(op, a);
        default:                do_nop(op, a);
      endcase
      if (k % 8 == 0) check_out();
    end
    check_out();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
